// File: rtl/game_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_cmd_pkg
//  Description : Shared constants and types for the game command parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_cmd_pkg;

    localparam logic [7:0] HDR       = 8'hA5;
    localparam logic [7:0] CMD_FLAP  = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;
    localparam logic [7:0] CMD_PAUSE = 8'h03;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_HDR = 2'd1,
        GOT_CMD = 2'd2
    } parse_state_t;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_FLAP) || (cmd == CMD_START) || (cmd == CMD_PAUSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_cmd_parser_if
//  Description : Byte input, frame sync and command/error outputs of the parser.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       vs_in;
    logic       cmd_flap;
    logic       cmd_start;
    logic       cmd_pause;
    logic       pkt_err;
    logic [7:0] err_cnt;

    modport master (
        output rx_data, rx_data_valid, vs_in,
        input  cmd_flap, cmd_start, cmd_pause, pkt_err, err_cnt
    );

    modport slave (
        input  rx_data, rx_data_valid, vs_in,
        output cmd_flap, cmd_start, cmd_pause, pkt_err, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/game_cmd_parser_frame_release.sv
`default_nettype none
// ============================================================================
//  Module      : frame_release
//  Description : Holds coalesced pending commands and releases them as
//                one-cycle pulses on the frame edge of vs_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_release #(
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_in,
    input  logic set_flap,
    input  logic set_start,
    input  logic set_pause,
    output logic cmd_flap,
    output logic cmd_start,
    output logic cmd_pause
);

    logic r_vs_d;
    logic r_flap_p;
    logic r_start_p;
    logic r_pause_p;
    logic w_edge;

    assign w_edge = (vs_in == VS_ACTIVE) && (r_vs_d != VS_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d    <= ~VS_ACTIVE;
            r_flap_p  <= 1'b0;
            r_start_p <= 1'b0;
            r_pause_p <= 1'b0;
            cmd_flap  <= 1'b0;
            cmd_start <= 1'b0;
            cmd_pause <= 1'b0;
        end else begin
            r_vs_d    <= vs_in;
            cmd_flap  <= w_edge & r_flap_p;
            cmd_start <= w_edge & r_start_p;
            cmd_pause <= w_edge & r_pause_p;

            // A command completing on the edge cycle is kept for the next frame.
            r_flap_p <= (r_flap_p & ~w_edge) | set_flap;
            if (set_start) begin
                r_start_p <= 1'b1;
                r_pause_p <= 1'b0;
            end else if (set_pause) begin
                r_start_p <= 1'b0;
                r_pause_p <= 1'b1;
            end else if (w_edge) begin
                r_start_p <= 1'b0;
                r_pause_p <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : game_cmd_parser
//  Description : Parses A5/CMD/~CMD packets, times out stalled packets and
//                hands valid commands to the per-frame release stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_cmd_parser
    import game_cmd_pkg::*;
#(
    parameter int   CLK_FRE    = 25,
    parameter int   TIMEOUT_MS = 20,
    parameter logic VS_ACTIVE  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    game_cmd_parser_if.slave   bus
);

    localparam int              TICKS   = CLK_FRE * 1000 * TIMEOUT_MS;
    localparam int              TO_W    = $clog2(TICKS + 1);
    localparam logic [TO_W-1:0] TO_TERM = TO_W'(TICKS - 1);

    parse_state_t    r_state;
    logic [7:0]      r_cmd;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic [7:0]      r_err_cnt;

    logic w_timeout;
    logic w_final;
    logic w_chk_ok;
    logic w_err;
    logic w_set_flap;
    logic w_set_start;
    logic w_set_pause;

    // A byte landing on the terminal cycle takes priority over the timeout.
    assign w_timeout = (r_state != IDLE) && !bus.rx_data_valid && (r_to_cnt == TO_TERM);
    assign w_final   = bus.rx_data_valid && (r_state == GOT_CMD);
    assign w_chk_ok  = (bus.rx_data == (r_cmd ^ 8'hFF)) && cmd_known(r_cmd);
    assign w_err     = w_timeout || (w_final && !w_chk_ok);

    assign w_set_flap  = w_final && w_chk_ok && (r_cmd == CMD_FLAP);
    assign w_set_start = w_final && w_chk_ok && (r_cmd == CMD_START);
    assign w_set_pause = w_final && w_chk_ok && (r_cmd == CMD_PAUSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cmd     <= 8'h00;
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'h01;
            end

            if (bus.rx_data_valid || (r_state == IDLE) || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state <= IDLE;
            end else if (bus.rx_data_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.rx_data == HDR) begin
                            r_state <= GOT_HDR;
                        end
                    end
                    GOT_HDR: begin
                        r_cmd   <= bus.rx_data;
                        r_state <= GOT_CMD;
                    end
                    GOT_CMD: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pkt_err = r_err;
    assign bus.err_cnt = r_err_cnt;

    frame_release #(
        .VS_ACTIVE (VS_ACTIVE)
    ) u_frame_release (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_in     (bus.vs_in),
        .set_flap  (w_set_flap),
        .set_start (w_set_start),
        .set_pause (w_set_pause),
        .cmd_flap  (bus.cmd_flap),
        .cmd_start (bus.cmd_start),
        .cmd_pause (bus.cmd_pause)
    );

endmodule
`default_nettype wire

// File: tb/tb_game_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_cmd_parser
//  Description : Directed and randomized bench for game_cmd_parser against a
//                packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_cmd_parser;

    // Short timeout keeps the stall scenarios within a few thousand cycles.
    localparam int CLK_FRE    = 1;
    localparam int TIMEOUT_MS = 1;
    localparam int TERM       = CLK_FRE * 1000 * TIMEOUT_MS - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    game_cmd_parser_if bus ();

    game_cmd_parser #(
        .CLK_FRE    (CLK_FRE),
        .TIMEOUT_MS (TIMEOUT_MS),
        .VS_ACTIVE  (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the packet in progress, idle gap, pending set.
    logic [7:0] pkt[$];
    int         gap;
    bit         fp, sp, pp;
    bit         vs_prev;
    bit         e_flap, e_start, e_pause, e_err;
    int         e_cnt;

    int  n_flap, n_start, n_pause, n_err, n_both;
    logic vs_lvl;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pkt.delete();
        gap     = 0;
        fp      = 1'b0;
        sp      = 1'b0;
        pp      = 1'b0;
        vs_prev = 1'b1;
        e_flap  = 1'b0;
        e_start = 1'b0;
        e_pause = 1'b0;
        e_err   = 1'b0;
        e_cnt   = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit vs);
        bit fedge;
        fedge   = (vs == 1'b0) && vs_prev;
        vs_prev = vs;
        e_flap  = 1'b0;
        e_start = 1'b0;
        e_pause = 1'b0;
        e_err   = 1'b0;
        if (fedge) begin
            e_flap  = fp;
            e_start = sp;
            e_pause = pp;
            fp = 1'b0;
            sp = 1'b0;
            pp = 1'b0;
        end
        if (v) begin
            gap = 0;
            if (pkt.size() == 0) begin
                if (d == 8'hA5) pkt.push_back(d);
            end else if (pkt.size() == 1) begin
                pkt.push_back(d);
            end else begin
                if (d == (pkt[1] ^ 8'hFF) && pkt[1] >= 8'd1 && pkt[1] <= 8'd3) begin
                    if (pkt[1] == 8'd1) fp = 1'b1;
                    else if (pkt[1] == 8'd2) begin sp = 1'b1; pp = 1'b0; end
                    else begin pp = 1'b1; sp = 1'b0; end
                end else begin
                    e_err = 1'b1;
                end
                pkt.delete();
            end
        end else if (pkt.size() != 0) begin
            gap++;
            if (gap > TERM) begin
                e_err = 1'b1;
                pkt.delete();
                gap = 0;
            end
        end
        if (e_err && e_cnt < 255) e_cnt++;
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        bus.rx_data_valid = v;
        bus.rx_data       = v ? d : 8'h00;
        bus.vs_in         = vs_lvl;
        @(posedge clk);
        model_step(v, d, vs_lvl);
        #1;
        n_flap  += int'(bus.cmd_flap);
        n_start += int'(bus.cmd_start);
        n_pause += int'(bus.cmd_pause);
        n_err   += int'(bus.pkt_err);
        n_both  += int'(bus.cmd_flap && bus.cmd_pause);
        check("cmd_flap",  {7'b0, bus.cmd_flap},  {7'b0, e_flap});
        check("cmd_start", {7'b0, bus.cmd_start}, {7'b0, e_start});
        check("cmd_pause", {7'b0, bus.cmd_pause}, {7'b0, e_pause});
        check("pkt_err",   {7'b0, bus.pkt_err},   {7'b0, e_err});
        check("err_cnt",   bus.err_cnt,           8'(e_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        step(1'b1, b0); step(1'b0, 8'h00);
        step(1'b1, b1); step(1'b0, 8'h00);
        step(1'b1, b2); step(1'b0, 8'h00);
    endtask

    task automatic frame();
        vs_lvl = 1'b0;
        idle(3);
        vs_lvl = 1'b1;
        idle(3);
    endtask

    task automatic clear_counts();
        n_flap = 0; n_start = 0; n_pause = 0; n_err = 0; n_both = 0;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.rx_data_valid = 1'b0;
        bus.rx_data       = 8'h00;
        vs_lvl            = 1'b1;
        bus.vs_in         = 1'b1;
        #1;
        model_reset();
        check("rst_flap",  {7'b0, bus.cmd_flap},  8'h00);
        check("rst_start", {7'b0, bus.cmd_start}, 8'h00);
        check("rst_pause", {7'b0, bus.cmd_pause}, 8'h00);
        check("rst_err",   {7'b0, bus.pkt_err},   8'h00);
        check("rst_cnt",   bus.err_cnt,           8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl [0:6];
        tbl[0] = 8'hA5; tbl[1] = 8'h01; tbl[2] = 8'h02; tbl[3] = 8'h03;
        tbl[4] = 8'hFE; tbl[5] = 8'hFD; tbl[6] = 8'hFC;
        vs_lvl = 1'b1;
        clear_counts();
        #3;
        do_reset();

        // Single flap
        clear_counts();
        send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("t1_flap_n",  8'(n_flap),  8'd1);
        check("t1_start_n", 8'(n_start), 8'd0);
        check("t1_err_n",   8'(n_err),   8'd0);

        // Coalescing, then an empty frame
        clear_counts();
        repeat (3) send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("t2_flap_n", 8'(n_flap), 8'd1);
        clear_counts();
        frame();
        check("t2_empty_n", 8'(n_flap), 8'd0);

        // Start then pause: last wins; flap shares the pulse cycle
        clear_counts();
        send_pkt(8'hA5, 8'h02, 8'hFD);
        send_pkt(8'hA5, 8'h03, 8'hFC);
        frame();
        check("t3_pause_n", 8'(n_pause), 8'd1);
        check("t3_start_n", 8'(n_start), 8'd0);
        clear_counts();
        send_pkt(8'hA5, 8'h02, 8'hFD);
        send_pkt(8'hA5, 8'h03, 8'hFC);
        send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("t3_both_n", 8'(n_both), 8'd1);

        // Bad checksum, unknown command, leading junk
        clear_counts();
        send_pkt(8'hA5, 8'h01, 8'h00);
        check("t4_err_n", 8'(n_err), 8'd1);
        check("t4_cnt1",  bus.err_cnt, 8'd1);
        send_pkt(8'hA5, 8'h07, 8'hF8);
        check("t4_cnt2",  bus.err_cnt, 8'd2);
        clear_counts();
        step(1'b1, 8'h3C);
        step(1'b1, 8'h11);
        send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("t4_junk_err", 8'(n_err),  8'd0);
        check("t4_junk_flap", 8'(n_flap), 8'd1);

        // Stall after header: exactly one timeout, then recovery
        clear_counts();
        step(1'b1, 8'hA5);
        idle(TERM + 20);
        check("t5_to_n",  8'(n_err), 8'd1);
        check("t5_cnt",   bus.err_cnt, 8'd3);
        send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("t5_after_flap", 8'(n_flap), 8'd1);

        // Bytes on the terminal cycle suppress the timeout
        clear_counts();
        step(1'b1, 8'hA5);
        idle(TERM);
        step(1'b1, 8'h01);
        idle(TERM);
        step(1'b1, 8'hFE);
        idle(2);
        frame();
        check("t5_term_err",  8'(n_err),  8'd0);
        check("t5_term_flap", 8'(n_flap), 8'd1);

        // Final byte coincident with the frame edge
        clear_counts();
        step(1'b1, 8'hA5); step(1'b0, 8'h00);
        step(1'b1, 8'h01); step(1'b0, 8'h00);
        vs_lvl = 1'b0;
        step(1'b1, 8'hFE);
        idle(3);
        vs_lvl = 1'b1;
        idle(3);
        check("t6_same_frame", 8'(n_flap), 8'd0);
        frame();
        check("t6_next_frame", 8'(n_flap), 8'd1);

        // Randomized traffic with random frame timing
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) vs_lvl = ~vs_lvl;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 7) == 0) step(1'b1, 8'($urandom));
                else step(1'b1, tbl[$urandom_range(0, 6)]);
            end else begin
                step(1'b0, 8'h00);
            end
        end
        vs_lvl = 1'b1;
        idle(4);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 8'hA5);
            step(1'b1, 8'h07);
            step(1'b1, 8'h00);
        end
        idle(2);
        check("sat_cnt", bus.err_cnt, 8'd255);

        // Reset in the middle of a packet
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        do_reset();
        clear_counts();
        step(1'b1, 8'hFE);
        frame();
        check("rst_mid_nflap", 8'(n_flap), 8'd0);
        send_pkt(8'hA5, 8'h01, 8'hFE);
        frame();
        check("rst_after_flap", 8'(n_flap), 8'd1);
        check("rst_after_cnt",  bus.err_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_cmd_parser.md
Name: game_cmd_parser

Overview:
- Sits between uart_rx and game_ctrl on the rgb_clk domain.
- Parses 3-byte command packets from the HC-01/BLE serial link and validates each one.
- Coalesces valid commands per video frame and releases them as single-cycle pulses on the frame edge of vs_in, so game physics sees at most one flap, start or pause per frame.
- Also reports malformed packets and timeouts.

Parameters:
- CLK_FRE, 25, clock frequency in MHz (matches uart_rx).
- TIMEOUT_MS, 20, maximum gap between bytes of one packet before abort.
- VS_ACTIVE, 1'b0, active level of vs_in; release happens on the transition into this level.

Ports:
- clk  input  1  system clock (rgb_clk, 25 MHz).
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  byte from uart_rx.
- rx_data_valid  input  1  one-cycle strobe qualifying rx_data.
- vs_in  input  1  vertical sync from rgb_timing.
- cmd_flap  output  1  one-cycle pulse: bird flap.
- cmd_start  output  1  one-cycle pulse: start/restart game.
- cmd_pause  output  1  one-cycle pulse: toggle pause.
- pkt_err  output  1  one-cycle pulse on checksum/unknown-command/timeout error.
- err_cnt  output  8  saturating count of pkt_err events.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, err_cnt=0, FSM=IDLE, pending flags cleared, timeout counter 0, vs_d=~VS_ACTIVE.
- Packet format: byte0=HDR 8'hA5, byte1=CMD, byte2=CMD^8'hFF.
- CMD codes: 8'h01 flap, 8'h02 start, 8'h03 pause. Any other code is an error.
- FSM states are IDLE, GOT_HDR and GOT_CMD. All transitions happen only on rx_data_valid, except timeout.
  - IDLE: byte==HDR -> GOT_HDR. Any other byte is discarded silently (no error).
  - GOT_HDR: latch byte as cmd -> GOT_CMD. A byte equal to A5 here is taken as CMD; it is not a resync.
  - GOT_CMD: byte==cmd^FF and cmd is known -> set the matching pending flag, then IDLE. Otherwise -> pkt_err, then IDLE.
- Timeout:
  - Counter width is $clog2(CLK_FRE*1000*TIMEOUT_MS+1); terminal value is CLK_FRE*1000*TIMEOUT_MS-1 (499999 by default).
  - The counter clears on every rx_data_valid and in IDLE, and counts while in GOT_HDR or GOT_CMD.
  - At the terminal value: pkt_err pulse, FSM -> IDLE, counter -> 0.
  - If a byte arrives on the terminal cycle, the byte wins and no timeout fires.
- Pending flags:
  - flap_p is set by any number of flaps within a frame, coalesced to one.
  - start_p and pause_p are mutually exclusive; the later command clears the other (last wins).
  - flap_p is independent of start_p and pause_p.
- Frame edge:
  - vs_d is a registered copy of vs_in.
  - edge = (vs_in==VS_ACTIVE) && (vs_d!=VS_ACTIVE).
  - On the edge cycle, outputs register the pending flags and the pending flags clear. Each cmd_* is high exactly one cycle, in the cycle after the edge.
- Simultaneous packet completion and edge: the pending clear takes effect and the new command is set pending. It releases on the next frame and is never lost.
- Latency: the last byte's valid at cycle N sets pending at N+1. The pulse appears the cycle after the next frame edge.
- pkt_err is registered: high the cycle after the error condition. err_cnt increments the same cycle pkt_err rises and saturates at 255.
- Reset asserted mid-packet or mid-pulse: immediate clear, no pulse completes. After release, the first accepted byte must be HDR.

Decomposition:
- Package game_cmd_pkg holds:
  - HDR=8'hA5.
  - CMD_FLAP/CMD_START/CMD_PAUSE localparams.
  - typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD} parse_state_t.
- The frame-edge release logic is a natural sub-module, frame_release (pending set/clear plus edge detect). The parser FSM and timeout stay in the top.

Test Plan:
- A5 01 FE, then one vs edge -> cmd_flap is 1 for exactly one cycle after the edge; cmd_start, cmd_pause and pkt_err stay 0.
- Three A5 01 FE packets within one frame -> one cmd_flap pulse. The following frame with no traffic -> no pulse.
- A5 02 FD then A5 03 FC in the same frame -> at the edge only cmd_pause pulses (last wins). A5 01 FE added -> cmd_flap pulses in the same cycle as cmd_pause.
- A5 01 00 -> pkt_err one cycle, err_cnt=1, no cmd. A5 07 F8 -> pkt_err, err_cnt=2. Junk 3C 11 before A5 01 FE -> no error, flap released.
- A5 then silence of 500000 cycles -> pkt_err exactly once, FSM in IDLE. A following A5 01 FE is accepted. A byte on the terminal cycle suppresses the timeout.
- Final check byte valid coincident with the vs edge -> no pulse this frame, cmd_flap at the next edge. rst_n pulsed low mid-packet -> outputs 0 and err_cnt 0, and A5 01 FE after release works.
